// File: rtl/hazard_intr_ctrl.sv
// Pipeline hazard and interrupt controller for a 5-stage core.
// Resolves load-use stalls, branch flushes and operand forwarding, and
// sequences interrupt entry: accept -> 3 drain cycles -> trap redirect.
module hazard_intr_ctrl (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        INTR,
  input  logic        int_en,
  input  logic [4:0]  rs1_D,
  input  logic [4:0]  rs2_D,
  input  logic        d_valid,
  input  logic [31:0] PC_D,
  input  logic [4:0]  rs1_E,
  input  logic [4:0]  rs2_E,
  input  logic [4:0]  rd_E,
  input  logic        memRead2_E,
  input  logic        pcSource_E,
  input  logic [4:0]  rd_M,
  input  logic        regWrite_M,
  input  logic [4:0]  rd_W,
  input  logic        regWrite_W,
  output logic        pcWrite,
  output logic        fd_ld,
  output logic        fd_flush,
  output logic        de_flush,
  output logic [1:0]  pc_sel,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic        intr_taken,
  output logic [31:0] mepc
);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_TRAP} state_t;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_BR    = 2'b01;
  localparam logic [1:0] PC_TVEC  = 2'b10;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

  // Last drain cycle is the one where the counter reads 2 (0,1,2).
  localparam logic [1:0] DRAIN_LAST = 2'd2;

  state_t     state_q, state_d;
  logic [1:0] drain_cnt;
  logic       intr_pending;
  logic       intr_req;
  logic       load_use;
  logic       accept;

  // Memory stage wins over Writeback since it holds the younger result.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rdm, input logic wem,
                                         input logic [4:0] rdw, input logic wew);
    if (wem && rdm != 5'd0 && rdm == rs)      return FWD_MEM;
    else if (wew && rdw != 5'd0 && rdw == rs) return FWD_WB;
    else                                      return FWD_RF;
  endfunction

  assign fwd_a_sel = fwd_sel(rs1_E, rd_M, regWrite_M, rd_W, regWrite_W);
  assign fwd_b_sel = fwd_sel(rs2_E, rd_M, regWrite_M, rd_W, regWrite_W);

  assign intr_req = intr_pending | (INTR & int_en);
  assign load_use = memRead2_E && (rd_E != 5'd0) &&
                    ((rd_E == rs1_D) || (rd_E == rs2_D));
  // Only take the interrupt on a real Decode instruction so mepc is meaningful,
  // and never under a redirect whose target PC is not yet in Decode.
  assign accept   = (state_q == S_RUN) && intr_req && !pcSource_E && d_valid;

  // Next-state and pipeline control; redirect > interrupt > load-use in RUN.
  always_comb begin
    state_d    = state_q;
    pcWrite    = 1'b1;
    fd_ld      = 1'b1;
    fd_flush   = 1'b0;
    de_flush   = 1'b0;
    pc_sel     = PC_PLUS4;
    intr_taken = 1'b0;
    case (state_q)
      S_RUN: begin
        if (pcSource_E) begin
          pc_sel   = PC_BR;
          fd_flush = 1'b1;
          de_flush = 1'b1;
        end else if (accept) begin
          pcWrite  = 1'b0;
          fd_flush = 1'b1;
          de_flush = 1'b1;
          state_d  = S_DRAIN;
        end else if (load_use) begin
          pcWrite  = 1'b0;
          fd_ld    = 1'b0;
          de_flush = 1'b1;
        end
      end
      S_DRAIN: begin
        pcWrite  = 1'b0;
        fd_flush = 1'b1;
        de_flush = 1'b1;
        if (drain_cnt == DRAIN_LAST) state_d = S_TRAP;
      end
      S_TRAP: begin
        pc_sel     = PC_TVEC;
        fd_flush   = 1'b1;
        de_flush   = 1'b1;
        intr_taken = 1'b1;
        state_d    = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
    // Reset holds the pipeline flushed while the PC reloads.
    if (RESET) begin
      state_d    = S_RUN;
      pcWrite    = 1'b1;
      fd_ld      = 1'b1;
      fd_flush   = 1'b1;
      de_flush   = 1'b1;
      pc_sel     = PC_PLUS4;
      intr_taken = 1'b0;
    end
  end

  // State, drain counter, pending flag and return PC.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= S_RUN;
      drain_cnt    <= 2'd0;
      intr_pending <= 1'b0;
      mepc         <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept)                  drain_cnt <= 2'd0;
      else if (state_q == S_DRAIN) drain_cnt <= drain_cnt + 2'd1;
      // Clearing on TRAP entry takes precedence; a still-high INTR re-arms in TRAP.
      if (state_q == S_DRAIN && state_d == S_TRAP) intr_pending <= 1'b0;
      else if (INTR && int_en)                     intr_pending <= 1'b1;
      if (accept) mepc <= PC_D;
    end
  end

endmodule

// File: tb/tb_hazard_intr_ctrl.sv
// Self-checking bench: directed scenarios then random traffic, all checked
// against a cycle-count model of the interrupt sequence and hazard rules.
module tb_hazard_intr_ctrl;

  logic        CLK = 1'b0;
  logic        RESET, INTR, int_en, d_valid, memRead2_E, pcSource_E;
  logic        regWrite_M, regWrite_W;
  logic [4:0]  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic [31:0] PC_D;
  logic        pcWrite, fd_ld, fd_flush, de_flush, intr_taken;
  logic [1:0]  pc_sel, fwd_a_sel, fwd_b_sel;
  logic [31:0] mepc;

  hazard_intr_ctrl dut (
    .CLK(CLK), .RESET(RESET), .INTR(INTR), .int_en(int_en),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .d_valid(d_valid), .PC_D(PC_D),
    .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
    .memRead2_E(memRead2_E), .pcSource_E(pcSource_E),
    .rd_M(rd_M), .regWrite_M(regWrite_M), .rd_W(rd_W), .regWrite_W(regWrite_W),
    .pcWrite(pcWrite), .fd_ld(fd_ld), .fd_flush(fd_flush), .de_flush(de_flush),
    .pc_sel(pc_sel), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .intr_taken(intr_taken), .mepc(mepc)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state: cycles elapsed since acceptance (0 = none in flight).
  int          m_since;
  bit          m_pend;
  logic [31:0] m_mepc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (regWrite_M && rd_M != 0 && rd_M == rs) return 2'd1;
    if (regWrite_W && rd_W != 0 && rd_W == rs) return 2'd2;
    return 2'd0;
  endfunction

  // Check the current cycle's outputs, then advance the model and the clock.
  task automatic step();
    logic [6:0] exp_ctl; // {pcWrite, fd_ld, fd_flush, de_flush, pc_sel, intr_taken}
    bit req, lu, acc;
    @(negedge CLK);
    req = m_pend || (INTR && int_en);
    lu  = memRead2_E && rd_E != 0 && (rd_E == rs1_D || rd_E == rs2_D);
    acc = 0;
    if (RESET)                         exp_ctl = 7'b1111_00_0;
    else if (m_since >= 1 && m_since <= 3) exp_ctl = 7'b0111_00_0;
    else if (m_since == 4)             exp_ctl = 7'b1111_10_1;
    else if (pcSource_E)               exp_ctl = 7'b1111_01_0;
    else if (req && d_valid) begin     exp_ctl = 7'b0111_00_0; acc = 1; end
    else if (lu)                       exp_ctl = 7'b0001_00_0;
    else                               exp_ctl = 7'b1100_00_0;
    chk("ctl",   {25'd0, pcWrite, fd_ld, fd_flush, de_flush, pc_sel, intr_taken}, {25'd0, exp_ctl});
    chk("fwd_a", {30'd0, fwd_a_sel}, {30'd0, ref_fwd(rs1_E)});
    chk("fwd_b", {30'd0, fwd_b_sel}, {30'd0, ref_fwd(rs2_E)});
    chk("mepc",  mepc, m_mepc);
    if (RESET) begin
      m_since = 0; m_pend = 0; m_mepc = 0;
    end else begin
      if (m_since == 3)           m_pend = 0;
      else if (INTR && int_en)    m_pend = 1;
      if (acc) begin m_since = 1; m_mepc = PC_D; end
      else if (m_since >= 1 && m_since <= 3) m_since++;
      else m_since = 0;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    RESET = 0; INTR = 0; int_en = 1; d_valid = 1; PC_D = 32'h0;
    rs1_D = 1; rs2_D = 2; rs1_E = 3; rs2_E = 4; rd_E = 0;
    memRead2_E = 0; pcSource_E = 0;
    rd_M = 0; regWrite_M = 0; rd_W = 0; regWrite_W = 0;
  endtask

  initial begin
    idle();
    RESET = 1;
    m_since = 0; m_pend = 0; m_mepc = 0;
    @(posedge CLK); #1;
    step(); step();                    // outputs and state under reset
    idle();

    // Load-use on rs2, then the same with rd_E = x0 (no stall)
    memRead2_E = 1; rd_E = 5; rs2_D = 5; step();
    rd_E = 0; rs2_D = 0; step();
    // Branch beats the load-use stall
    rd_E = 5; rs1_D = 5; pcSource_E = 1; step();
    idle();

    // Forwarding priority: Memory, then Writeback, then x0 never forwards
    rd_M = 7; rd_W = 7; regWrite_M = 1; regWrite_W = 1; rs1_E = 7; rs2_E = 7; step();
    regWrite_M = 0; step();
    rs1_E = 0; rs2_E = 0; step();
    idle();

    // Interrupt: accept, 3 drain cycles, trap on the 4th, back to RUN
    INTR = 1; PC_D = 32'h100; step();
    INTR = 0; PC_D = 32'h104;
    chk("mepc_int", mepc, 32'h100);
    repeat (3) begin
      chk("drain_pw", {31'd0, pcWrite}, 32'd0);
      step();
    end
    chk("trap_it",  {31'd0, intr_taken}, 32'd1);
    chk("trap_sel", {30'd0, pc_sel}, 32'd2);
    step();
    chk("run_pw",   {31'd0, pcWrite}, 32'd1);
    step();

    // Deferral: one-cycle INTR under a redirect, then taken next cycle
    INTR = 1; pcSource_E = 1; PC_D = 32'h200; step();
    INTR = 0; pcSource_E = 0; PC_D = 32'h204; step();
    chk("mepc_def", mepc, 32'h204);
    repeat (5) step();
    // Deferral on a bubble in Decode
    INTR = 1; d_valid = 0; PC_D = 32'h300; step();
    INTR = 0; step();
    d_valid = 1; PC_D = 32'h308; step();
    repeat (5) step();

    // Reset mid-drain: no trap pulse afterwards, pending and mepc cleared
    INTR = 1; PC_D = 32'h400; step();
    INTR = 0; step();                  // drain count 0
    RESET = 1; step();                 // drain count 1
    RESET = 0;
    chk("rst_mepc", mepc, 32'h0);
    repeat (6) step();

    // Random traffic with small register ranges to provoke matches
    for (int i = 0; i < 3000; i++) begin
      RESET      = ($urandom_range(0, 99) == 0);
      INTR       = ($urandom_range(0, 9) == 0);
      int_en     = ($urandom_range(0, 3) != 0);
      d_valid    = ($urandom_range(0, 4) != 0);
      PC_D       = $urandom & 32'hFFFF_FFFC;
      rs1_D      = 5'($urandom_range(0, 3));
      rs2_D      = 5'($urandom_range(0, 3));
      rs1_E      = 5'($urandom_range(0, 3));
      rs2_E      = 5'($urandom_range(0, 3));
      rd_E       = 5'($urandom_range(0, 3));
      rd_M       = 5'($urandom_range(0, 3));
      rd_W       = 5'($urandom_range(0, 3));
      memRead2_E = $urandom_range(0, 1) == 1;
      pcSource_E = ($urandom_range(0, 4) == 0);
      regWrite_M = $urandom_range(0, 1) == 1;
      regWrite_W = $urandom_range(0, 1) == 1;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_intr_ctrl.md
HAZARD_INTR_CTRL -- requirements
Module: hazard_intr_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 CLK  in  1  system clock; all state updates on the rising edge.
REQ-003 RESET  in  1  synchronous, active-high reset.
REQ-004 INTR  in  1  level interrupt request.
REQ-005 int_en  in  1  interrupt enable (mstatus.MIE).
REQ-006 rs1_D, rs2_D  in  5 each  source register addresses of the instruction in Decode.
REQ-007 d_valid  in  1  Decode holds a real instruction, not a bubble.
REQ-008 PC_D  in  32  PC of the instruction in Decode.
REQ-009 rs1_E, rs2_E, rd_E  in  5 each  register addresses of the instruction in Execute.
REQ-010 memRead2_E  in  1  the instruction in Execute is a load.
REQ-011 pcSource_E  in  1  a taken branch or jump is in Execute.
REQ-012 rd_M, regWrite_M, rd_W, regWrite_W  in  5/1/5/1  destination register and write enable for Memory and Writeback.
REQ-013 pcWrite  out  1  PC load enable.
REQ-014 fd_ld  out  1  Fetch/Decode register load enable.
REQ-015 fd_flush, de_flush  out  1 each  bubble insert into the Fetch/Decode and Decode/Execute registers.
REQ-016 pc_sel  out  2  PC source: 00 = PC+4, 01 = branch target, 10 = mtvec.
REQ-017 fwd_a_sel, fwd_b_sel  out  2 each  ALU operand source: 00 = register file, 01 = Memory-stage ALU result, 10 = Writeback data.
REQ-018 intr_taken  out  1  one-cycle pulse when the trap redirect occurs.
REQ-019 mepc  out  32  registered return PC.

Function
REQ-020 The FSM SHALL have three states: RUN, DRAIN and TRAP, plus a 2-bit drain counter and an intr_pending flag.
REQ-021 Default outputs in RUN SHALL be: pcWrite=1, fd_ld=1, flushes=0, pc_sel=00, intr_taken=0.
REQ-022 Load-use stall SHALL be detected when, in RUN, memRead2_E=1, rd_E!=0 and rd_E equals rs1_D or rs2_D.
REQ-023 On a load-use stall the block SHALL drive pcWrite=0, fd_ld=0 and de_flush=1 for exactly that cycle (1-cycle bubble).
REQ-024 When pcSource_E=1 in RUN the block SHALL drive pc_sel=01, fd_flush=1 and de_flush=1.
REQ-025 pcSource_E SHALL take priority over a load-use stall: pcWrite=1 and fd_ld=1 in that cycle.
REQ-026 fwd_a_sel SHALL be 01 if regWrite_M=1, rd_M!=0 and rd_M==rs1_E.
REQ-027 Otherwise fwd_a_sel SHALL be 10 if regWrite_W=1, rd_W!=0 and rd_W==rs1_E.
REQ-028 Otherwise fwd_a_sel SHALL be 00.
REQ-029 fwd_b_sel SHALL follow the same rules using rs2_E.
REQ-030 Forwarding SHALL be combinational and active in every state.
REQ-031 intr_pending SHALL set when INTR=1 and int_en=1.
REQ-032 intr_pending SHALL hold until the TRAP state is entered, then clear.
REQ-033 Interrupt acceptance SHALL occur in RUN when intr_pending (or INTR&int_en) = 1, pcSource_E=0 and d_valid=1.
REQ-034 On acceptance, in the same cycle: mepc<=PC_D, de_flush=1, fd_flush=1, pcWrite=0; next state DRAIN, counter<=0.
REQ-035 If pcSource_E=1 or d_valid=0 on a request cycle, acceptance SHALL be deferred while pending stays set.
REQ-036 In DRAIN the block SHALL drive pcWrite=0, fd_flush=1 and de_flush=1, and increment the counter each cycle.
REQ-037 DRAIN SHALL last exactly 3 cycles, then the FSM SHALL go to TRAP.
REQ-038 Load-use and pcSource_E SHALL be ignored in DRAIN and TRAP.
REQ-039 TRAP SHALL last one cycle with pc_sel=10, pcWrite=1, fd_flush=1, de_flush=1 and intr_taken=1, then return to RUN.
REQ-040 Dropping INTR after acceptance SHALL NOT abort DRAIN or TRAP.
REQ-041 Total latency from acceptance to intr_taken SHALL be 4 cycles.

Reset
REQ-042 RESET SHALL force state=RUN, counter=0, intr_pending=0 and mepc=0 at the next edge, from any state, including mid-DRAIN.
REQ-043 While RESET=1 the outputs SHALL be: pcWrite=1, fd_ld=1, fd_flush=1, de_flush=1, pc_sel=00, intr_taken=0.

Verification
REQ-044 Load-use: memRead2_E=1, rd_E=5, rs2_D=5 -> one cycle of pcWrite=0, fd_ld=0, de_flush=1; with rd_E=0 -> no stall.
REQ-045 Branch versus stall: pcSource_E=1 with load-use true -> pc_sel=01, fd_flush=1, de_flush=1, pcWrite=1.
REQ-046 Forwarding: rd_M=rd_W=7, both write enables=1, rs1_E=7 -> fwd_a_sel=01; with regWrite_M=0 -> fwd_a_sel=10; with rs1_E=0 -> 00.
REQ-047 Interrupt: INTR=1, int_en=1, d_valid=1, PC_D=0x100 -> mepc=0x100, 3 DRAIN cycles, then intr_taken=1 with pc_sel=10 on cycle 4, then RUN.
REQ-048 Deferral: INTR pulsed for one cycle while pcSource_E=1 -> no acceptance that cycle; acceptance on the next cycle with d_valid=1 (pending held).
REQ-049 Reset mid-DRAIN: RESET at drain count 1 -> next cycle in RUN, intr_pending=0, mepc=0, no intr_taken pulse.
